rab_cfg_lite_slave: RTL and testbench
=====================================

Name: rab_cfg_lite_slave

Overview:
AXI4-Lite responder that terminates the RAB configuration bus and holds the slice registers. These are the registers that host/testbench initiators program with sequential AW, W and B transactions.
- One instance serves one RAB direction; each instance decodes a 4 KiB window.
- Slice contents are driven out as flat register arrays to the RAB lookup logic.
- Channels are independent, with one outstanding write and one outstanding read, which matches the single-beat initiator tasks used across the team's benches.

Parameters:
- N_SLICES, 32: number of slices in this window (max 128).
- AXI_AW, 64: width of the first/last/base address fields.
- BASE_ADDR, 32'hA800_0000: window base; window size is fixed at 32'h1000.
- axi_lite_req_t, logic: AXI-Lite request struct (32-bit addr, 32-bit data).
- axi_lite_resp_t, logic: AXI-Lite response struct.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- axi_lite_req_i  in  axi_lite_req_t  AW/W/AR channels, plus b_ready and r_ready.
- axi_lite_resp_o  out  axi_lite_resp_t  aw_ready/w_ready/ar_ready, plus the B and R channels.
- slice_first_o  out  N_SLICES x AXI_AW  first address of each slice.
- slice_last_o  out  N_SLICES x AXI_AW  last address of each slice (inclusive).
- slice_base_o  out  N_SLICES x AXI_AW  translated base of each slice.
- slice_flags_o  out  N_SLICES x 3  [0] enable, [1] read allowed, [2] write allowed.
- slice_upd_o  out  N_SLICES  one-cycle pulse when that slice's flags word is written.

Behaviour:
- Reset (async, rst_ni=0):
  - All slice registers are 0; slice_upd_o=0.
  - b_valid=0, r_valid=0, r.data=0, resp fields=0.
  - AW and W holding slots are empty; aw_ready=w_ready=ar_ready=1.
- Address decoding uses off = addr - BASE_ADDR, and only the low 12 bits are used.
  - slice = off[11:5]; word = off[4:2]; off[1:0] are ignored.
  - Outside the window (addr < BASE_ADDR or addr >= BASE_ADDR+0x1000), or slice >= N_SLICES: response is DECERR (2'b11).
- Word map within a slice:
  - 0 = first[31:0], 1 = first[63:32]
  - 2 = last[31:0], 3 = last[63:32]
  - 4 = base[31:0], 5 = base[63:32]
  - 6 = flags (bits [2:0]; upper bits read as 0)
  - 7 = reserved: writes are ignored and reads return 0, both with OKAY.
  - Bits at or above AXI_AW are not stored and read as 0. If AXI_AW <= 32, the hi words behave as reserved.
- Write path:
  - aw_ready = ~aw_full and w_ready = ~w_full. A handshake sets the corresponding slot full and captures addr or data+strb.
  - AW and W may arrive in either order or in the same cycle.
  - Commit happens in the cycle where both slots are full and b_valid=0:
    - Update bytes per strb; strb=0 means no change, but the response is still OKAY.
    - Clear both slots; set b_valid=1 with b.resp.
    - Pulse slice_upd_o[slice] if word==6 and strb[0]=1.
  - The new register value is visible on the outputs one cycle after commit.
  - b_valid holds until b_ready; slots refill only after commit, which caps outstanding writes at 1.
  - A decode error produces no register change.
- Read path:
  - ar_ready = ~r_valid. On AR handshake, r.data and r.resp are registered and r_valid=1 the next cycle.
  - r.data and r.resp hold stable until r_ready, and r_valid drops in the cycle after the handshake.
  - Reads return the register content as of the AR handshake cycle. A write committing in that same cycle is not reflected (old value is returned).
- Channel independence: reads and writes never stall each other.
- Reset mid-transaction: slots are dropped and valids are cleared immediately. No B or R is issued for a transaction interrupted by reset.

Decomposition:
- rab_pkg holds:
  - RAB_CFG_WIN_SIZE = 32'h1000 and RAB_SLICE_STRIDE = 32'h20.
  - Word-index constants (FIRST_LO … FLAGS = 6).
  - The typedef rab_flags_t, a packed struct {wr_en, rd_en, en}.
- Response codes come from axi_pkg (RESP_OKAY, RESP_DECERR).
- Natural sub-module rab_cfg_decode: combinational addr → {slice, word, hit}, instantiated once each for AW and AR.

Test Plan:
1. Write 32'h0000_1000 to BASE+0x1000+0x00, in a second instance with BASE_ADDR=32'hA800_1000: expect B OKAY, first[0]=0x1000, and no change in the other instance.
2. Write first_lo=0x1, first_hi=0x000F_FFFF, then flags=0x7 to slice 0: expect first=64'h000F_FFFF_0000_0001, flags=3'b111, slice_upd_o[0] pulsing exactly 1 cycle, then a read of word 6 returning 0x7 OKAY.
3. W presented 3 cycles before AW, with b_ready held low for 5 cycles: expect aw/w_ready=0 while the slots are full, b_valid held stable, and no second commit.
4. Write strb=4'b0010 with data 0xAABBCCDD to base_lo previously holding 0x11223344: expect readback 0x1122CC44.
5. Read BASE+0x400 with N_SLICES=32: expect DECERR and data 0. Write to 32'hA900_0000: expect B DECERR and all registers unchanged.
6. Assert rst_ni=0 while b_valid=1 and r_valid=1: expect both valids, all slices and all readies back to their reset values immediately, and no spurious B after release.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI4-Lite response codes and the single-beat request/response structs shared by RAB blocks.
// Only the fields a single-outstanding, non-burst responder needs are carried.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
  } axi_lite_resp_t;

endpackage

// File: rtl/rab_pkg.sv
// RAB configuration window geometry, per-slice word map and byte-merge helpers.
// Pure declarations; no timing or flow control.
package rab_pkg;

  localparam logic [31:0] RAB_CFG_WIN_SIZE = 32'h1000;
  localparam logic [31:0] RAB_SLICE_STRIDE = 32'h20;

  localparam logic [2:0] FIRST_LO = 3'd0;
  localparam logic [2:0] FIRST_HI = 3'd1;
  localparam logic [2:0] LAST_LO  = 3'd2;
  localparam logic [2:0] LAST_HI  = 3'd3;
  localparam logic [2:0] BASE_LO  = 3'd4;
  localparam logic [2:0] BASE_HI  = 3'd5;
  localparam logic [2:0] FLAGS    = 3'd6;
  localparam logic [2:0] RSVD     = 3'd7;

  typedef struct packed {
    logic wr_en;
    logic rd_en;
    logic en;
  } rab_flags_t;

  // Byte-lane update of one 32-bit half of a 64-bit address register.
  function automatic logic [63:0] merge_word(input logic [63:0] old_val,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb,
                                             input logic        hi);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        if (hi) res[32 + 8*b +: 8] = data[8*b +: 8];
        else    res[8*b +: 8]      = data[8*b +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] pick_word(input logic [63:0] val, input logic hi);
    return hi ? val[63:32] : val[31:0];
  endfunction

endpackage

// File: rtl/rab_cfg_decode.sv
// Combinational decode of a bus address into slice index, word index and window hit.
// Zero latency; no flow control.
module rab_cfg_decode
  import rab_pkg::*;
#(
  parameter int          N_SLICES  = 32,
  parameter logic [31:0] BASE_ADDR = 32'hA800_0000
) (
  input  logic [31:0] i_addr,
  output logic [6:0]  o_slice,
  output logic [2:0]  o_word,
  output logic        o_hit
);

  localparam int          SLICE_LSB = $clog2(RAB_SLICE_STRIDE);
  localparam logic [32:0] WIN_END   = {1'b0, BASE_ADDR} + {1'b0, RAB_CFG_WIN_SIZE};
  localparam logic [7:0]  N_SL      = 8'(N_SLICES);

  logic [31:0] w_off;
  logic        w_in_win;
  logic        w_unused_off;

  assign w_off    = i_addr - BASE_ADDR;
  // 33-bit compare keeps a window at the top of the address map from wrapping.
  assign w_in_win = (i_addr >= BASE_ADDR) && ({1'b0, i_addr} < WIN_END);
  assign o_slice  = w_off[SLICE_LSB +: 7];
  assign o_word   = w_off[4:2];
  assign o_hit    = w_in_win && ({1'b0, o_slice} < N_SL);

  assign w_unused_off = ^{w_off[31:12], w_off[1:0]};

endmodule

// File: rtl/rab_cfg_lite_slave.sv
// AXI4-Lite slave holding RAB slice registers; write commits one cycle after AW+W are both held, read data one cycle after AR.
// One outstanding write and one outstanding read; slots and R stall on b_ready/r_ready only.
module rab_cfg_lite_slave
  import rab_pkg::*;
#(
  parameter int          N_SLICES        = 32,
  parameter int          AXI_AW          = 64,
  parameter logic [31:0] BASE_ADDR       = 32'hA800_0000,
  parameter type         axi_lite_req_t  = axi_pkg::axi_lite_req_t,
  parameter type         axi_lite_resp_t = axi_pkg::axi_lite_resp_t
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  axi_lite_req_t                      axi_lite_req_i,
  output axi_lite_resp_t                     axi_lite_resp_o,
  output logic [N_SLICES-1:0][AXI_AW-1:0]    slice_first_o,
  output logic [N_SLICES-1:0][AXI_AW-1:0]    slice_last_o,
  output logic [N_SLICES-1:0][AXI_AW-1:0]    slice_base_o,
  output logic [N_SLICES-1:0][2:0]           slice_flags_o,
  output logic [N_SLICES-1:0]                slice_upd_o
);

  logic        r_aw_full, r_w_full, r_b_valid, r_r_valid;
  logic [31:0] r_aw_addr, r_w_data, r_r_data;
  logic [3:0]  r_w_strb;
  logic [1:0]  r_b_resp, r_r_resp;

  logic [N_SLICES-1:0][AXI_AW-1:0] r_first, r_last, r_base;
  logic [N_SLICES-1:0][2:0]        r_flags;
  logic [N_SLICES-1:0]             r_upd;

  logic [6:0]  w_aw_slice, w_ar_slice;
  logic [2:0]  w_aw_word, w_ar_word;
  logic        w_aw_hit, w_ar_hit;
  logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_commit;
  logic [31:0] w_rd_data;
  rab_flags_t  w_new_flags;

  rab_cfg_decode #(.N_SLICES(N_SLICES), .BASE_ADDR(BASE_ADDR)) u_aw_dec (
    .i_addr  (r_aw_addr),
    .o_slice (w_aw_slice),
    .o_word  (w_aw_word),
    .o_hit   (w_aw_hit)
  );

  rab_cfg_decode #(.N_SLICES(N_SLICES), .BASE_ADDR(BASE_ADDR)) u_ar_dec (
    .i_addr  (axi_lite_req_i.ar_addr),
    .o_slice (w_ar_slice),
    .o_word  (w_ar_word),
    .o_hit   (w_ar_hit)
  );

  assign w_aw_hs     = axi_lite_req_i.aw_valid & ~r_aw_full;
  assign w_w_hs      = axi_lite_req_i.w_valid  & ~r_w_full;
  assign w_b_hs      = r_b_valid & axi_lite_req_i.b_ready;
  assign w_ar_hs     = axi_lite_req_i.ar_valid & ~r_r_valid;
  assign w_r_hs      = r_r_valid & axi_lite_req_i.r_ready;
  // A pending B blocks the next commit, which caps outstanding writes at one.
  assign w_commit    = r_aw_full & r_w_full & ~r_b_valid;
  assign w_new_flags = rab_flags_t'(r_w_data[2:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_b_valid <= 1'b0;
      r_b_resp  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= axi_lite_req_i.aw_addr;
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= axi_lite_req_i.w_data;
        r_w_strb <= axi_lite_req_i.w_strb;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
      if (w_commit) begin
        r_b_valid <= 1'b1;
        r_b_resp  <= w_aw_hit ? axi_pkg::RESP_OKAY : axi_pkg::RESP_DECERR;
      end else if (w_b_hs) begin
        r_b_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_first <= '0;
      r_last  <= '0;
      r_base  <= '0;
      r_flags <= '0;
      r_upd   <= '0;
    end else begin
      r_upd <= '0;
      for (int s = 0; s < N_SLICES; s++) begin
        if (w_commit && w_aw_hit && (w_aw_slice == 7'(s))) begin
          // Halves above AXI_AW are dropped by the truncating cast.
          case (w_aw_word)
            FIRST_LO, FIRST_HI:
              r_first[s] <= AXI_AW'(merge_word(64'(r_first[s]), r_w_data, r_w_strb, w_aw_word[0]));
            LAST_LO, LAST_HI:
              r_last[s]  <= AXI_AW'(merge_word(64'(r_last[s]), r_w_data, r_w_strb, w_aw_word[0]));
            BASE_LO, BASE_HI:
              r_base[s]  <= AXI_AW'(merge_word(64'(r_base[s]), r_w_data, r_w_strb, w_aw_word[0]));
            FLAGS: begin
              if (r_w_strb[0]) begin
                r_flags[s] <= w_new_flags;
                r_upd[s]   <= 1'b1;
              end
            end
            RSVD: ;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int s = 0; s < N_SLICES; s++) begin
      if (w_ar_hit && (w_ar_slice == 7'(s))) begin
        case (w_ar_word)
          FIRST_LO, FIRST_HI: w_rd_data = pick_word(64'(r_first[s]), w_ar_word[0]);
          LAST_LO, LAST_HI:   w_rd_data = pick_word(64'(r_last[s]), w_ar_word[0]);
          BASE_LO, BASE_HI:   w_rd_data = pick_word(64'(r_base[s]), w_ar_word[0]);
          FLAGS:              w_rd_data = {29'd0, r_flags[s]};
          default:            w_rd_data = '0;
        endcase
      end
    end
  end

  // Sampling here returns pre-commit contents when a write lands in the AR cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_r_valid <= 1'b0;
      r_r_data  <= '0;
      r_r_resp  <= '0;
    end else if (w_ar_hs) begin
      r_r_valid <= 1'b1;
      r_r_data  <= w_rd_data;
      r_r_resp  <= w_ar_hit ? axi_pkg::RESP_OKAY : axi_pkg::RESP_DECERR;
    end else if (w_r_hs) begin
      r_r_valid <= 1'b0;
    end
  end

  always_comb begin
    axi_lite_resp_o          = '0;
    axi_lite_resp_o.aw_ready = ~r_aw_full;
    axi_lite_resp_o.w_ready  = ~r_w_full;
    axi_lite_resp_o.b_valid  = r_b_valid;
    axi_lite_resp_o.b_resp   = r_b_resp;
    axi_lite_resp_o.ar_ready = ~r_r_valid;
    axi_lite_resp_o.r_valid  = r_r_valid;
    axi_lite_resp_o.r_data   = r_r_data;
    axi_lite_resp_o.r_resp   = r_r_resp;
  end

  assign slice_first_o = r_first;
  assign slice_last_o  = r_last;
  assign slice_base_o  = r_base;
  assign slice_flags_o = r_flags;
  assign slice_upd_o   = r_upd;

endmodule

// File: tb/tb_rab_cfg_lite_slave.sv
// Bench for rab_cfg_lite_slave: directed scenarios plus random AXI-Lite traffic against a word-map model.
module tb_rab_cfg_lite_slave;
  import axi_pkg::*;

  localparam int          N      = 32;
  localparam int          AW     = 64;
  localparam logic [31:0] BASE   = 32'hA800_0000;
  localparam logic [31:0] BASE_B = 32'hA800_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_req_t  req, req_a, req_b;
  axi_lite_resp_t rsp, rsp_a, rsp_b;
  logic           tgt = 1'b0;

  assign req_a = tgt ? axi_lite_req_t'(0) : req;
  assign req_b = tgt ? req : axi_lite_req_t'(0);
  assign rsp   = tgt ? rsp_b : rsp_a;

  logic [N-1:0][AW-1:0] first_a, last_a, base_a, first_b, last_b, base_b;
  logic [N-1:0][2:0]    flags_a, flags_b;
  logic [N-1:0]         upd_a, upd_b;

  rab_cfg_lite_slave #(.N_SLICES(N), .AXI_AW(AW), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .axi_lite_req_i(req_a), .axi_lite_resp_o(rsp_a),
    .slice_first_o(first_a), .slice_last_o(last_a), .slice_base_o(base_a),
    .slice_flags_o(flags_a), .slice_upd_o(upd_a));

  rab_cfg_lite_slave #(.N_SLICES(N), .AXI_AW(AW), .BASE_ADDR(BASE_B)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .axi_lite_req_i(req_b), .axi_lite_resp_o(rsp_b),
    .slice_first_o(first_b), .slice_last_o(last_b), .slice_base_o(base_b),
    .slice_flags_o(flags_b), .slice_upd_o(upd_b));

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_first[N], m_last[N], m_base[N];
  logic [2:0]  m_flags[N];
  int          upd_exp[N], upd_seen[N];

  always @(negedge clk) begin
    for (int s = 0; s < N; s++) if (upd_a[s]) upd_seen[s]++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit decode_m(input logic [31:0] addr, output int sl, output int wd);
    sl = 0;
    wd = 0;
    if (addr < BASE || addr >= BASE + 32'h1000) return 1'b0;
    sl = int'((addr - BASE) / 32);
    wd = int'(((addr - BASE) % 32) / 4);
    return sl < N;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < N; s++) begin
      m_first[s] = '0; m_last[s] = '0; m_base[s] = '0; m_flags[s] = '0;
    end
  endtask

  task automatic model_write(input logic [31:0] addr, data, input logic [3:0] strb,
                             output logic [1:0] resp);
    int sl, wd;
    logic [63:0] v;
    if (!decode_m(addr, sl, wd)) begin
      resp = RESP_DECERR;
      return;
    end
    resp = RESP_OKAY;
    if (wd < 6) begin
      v = (wd < 2) ? m_first[sl] : (wd < 4) ? m_last[sl] : m_base[sl];
      for (int b = 0; b < 4; b++) if (strb[b]) v[(wd % 2) * 32 + 8 * b +: 8] = data[8 * b +: 8];
      if (wd < 2) m_first[sl] = v;
      else if (wd < 4) m_last[sl] = v;
      else m_base[sl] = v;
    end else if (wd == 6 && strb[0]) begin
      m_flags[sl] = data[2:0];
      upd_exp[sl]++;
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    int sl, wd;
    logic [63:0] v;
    data = '0;
    if (!decode_m(addr, sl, wd)) begin
      resp = RESP_DECERR;
      return;
    end
    resp = RESP_OKAY;
    if (wd < 6) begin
      v = (wd < 2) ? m_first[sl] : (wd < 4) ? m_last[sl] : m_base[sl];
      data = (wd % 2 == 1) ? v[63:32] : v[31:0];
    end else if (wd == 6) begin
      data = {29'd0, m_flags[sl]};
    end
  endtask

  task automatic check_all(input string tag);
    for (int s = 0; s < N; s++) begin
      check_eq($sformatf("%s first[%0d]", tag, s), first_a[s], m_first[s]);
      check_eq($sformatf("%s last[%0d]", tag, s), last_a[s], m_last[s]);
      check_eq($sformatf("%s base[%0d]", tag, s), base_a[s], m_base[s]);
      check_eq($sformatf("%s flags[%0d]", tag, s), flags_a[s], m_flags[s]);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " aw_ready"}, rsp.aw_ready, 1);
    check_eq({tag, " w_ready"}, rsp.w_ready, 1);
    check_eq({tag, " ar_ready"}, rsp.ar_ready, 1);
    check_eq({tag, " b_valid"}, rsp.b_valid, 0);
    check_eq({tag, " r_valid"}, rsp.r_valid, 0);
  endtask

  // ---------------- bus tasks (all drive/sample at negedge) ----------------
  // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
  task automatic write_req(input logic [31:0] addr, data, input logic [3:0] strb,
                           input int lead, input bit hold_chk);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int t = 0;
    int aw_start = (lead > 0) ? lead : 0;
    int w_start  = (lead < 0) ? -lead : 0;
    @(negedge clk);
    req.aw_addr  = addr;
    req.w_data   = data;
    req.w_strb   = strb;
    req.aw_valid = (aw_start == 0);
    req.w_valid  = (w_start == 0);
    while (!(aw_done && w_done)) begin
      if (t > 200) begin
        check_eq("aw_w_timeout", 1, 0);
        req.aw_valid = 0;
        req.w_valid  = 0;
        return;
      end
      aw_hs = req.aw_valid && rsp.aw_ready;
      w_hs  = req.w_valid && rsp.w_ready;
      @(negedge clk);
      t++;
      if (aw_hs) begin req.aw_valid = 0; aw_done = 1; end
      if (w_hs)  begin req.w_valid = 0;  w_done = 1;  end
      if (!aw_done && t >= aw_start) req.aw_valid = 1;
      if (!w_done && t >= w_start) req.w_valid = 1;
      if (hold_chk && w_done && !aw_done) check_eq("w_ready_while_full", rsp.w_ready, 0);
    end
    if (hold_chk) begin
      check_eq("aw_ready_both_full", rsp.aw_ready, 0);
      check_eq("w_ready_both_full", rsp.w_ready, 0);
    end
  endtask

  task automatic collect_b(input int hold, output logic [1:0] resp);
    int t = 0;
    logic [1:0] r0;
    resp = 2'b01;
    while (!rsp.b_valid) begin
      if (t > 200) begin check_eq("b_timeout", 1, 0); return; end
      @(negedge clk);
      t++;
    end
    r0 = rsp.b_resp;
    repeat (hold) begin
      @(negedge clk);
      check_eq("b_valid_hold", rsp.b_valid, 1);
      check_eq("b_resp_hold", rsp.b_resp, r0);
    end
    req.b_ready = 1;
    @(negedge clk);
    req.b_ready = 0;
    check_eq("b_valid_drop", rsp.b_valid, 0);
    resp = r0;
  endtask

  task automatic read_req(input logic [31:0] addr);
    int t = 0;
    @(negedge clk);
    req.ar_addr  = addr;
    req.ar_valid = 1;
    while (!rsp.ar_ready) begin
      if (t > 200) begin check_eq("ar_timeout", 1, 0); req.ar_valid = 0; return; end
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    req.ar_valid = 0;
  endtask

  task automatic collect_r(input int hold, output logic [31:0] data, output logic [1:0] resp);
    int t = 0;
    logic [31:0] d0;
    logic [1:0]  r0;
    data = 32'hDEAD_BEEF;
    resp = 2'b01;
    while (!rsp.r_valid) begin
      if (t > 200) begin check_eq("r_timeout", 1, 0); return; end
      @(negedge clk);
      t++;
    end
    d0 = rsp.r_data;
    r0 = rsp.r_resp;
    repeat (hold) begin
      @(negedge clk);
      check_eq("r_data_hold", rsp.r_data, d0);
      check_eq("r_resp_hold", rsp.r_resp, r0);
    end
    req.r_ready = 1;
    @(negedge clk);
    req.r_ready = 0;
    check_eq("r_valid_drop", rsp.r_valid, 0);
    data = d0;
    resp = r0;
  endtask

  task automatic do_write(input logic [31:0] addr, data, input logic [3:0] strb,
                          input int lead, input int hold, input bit hold_chk);
    logic [1:0] r, er;
    write_req(addr, data, strb, lead, hold_chk);
    collect_b(hold, r);
    model_write(addr, data, strb, er);
    check_eq($sformatf("b_resp@%h", addr), r, er);
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold, output logic [31:0] d);
    logic [1:0]  r, er;
    logic [31:0] ed;
    read_req(addr);
    collect_r(hold, d, r);
    model_read(addr, ed, er);
    check_eq($sformatf("r_resp@%h", addr), r, er);
    check_eq($sformatf("r_data@%h", addr), d, ed);
  endtask

  function automatic logic [31:0] rand_addr();
    int k = int'($urandom_range(0, 19));
    if (k == 0) return BASE - 32'($urandom_range(1, 64));
    if (k == 1) return BASE + 32'h1000 + 32'($urandom_range(0, 64));
    if (k == 2) return BASE + 32'h400 + 32'($urandom_range(0, 32'hBFF));
    return BASE + 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          u0, seen_b;

    req = axi_lite_req_t'(0);
    model_reset();
    for (int s = 0; s < N; s++) begin upd_exp[s] = 0; end
    repeat (3) @(negedge clk);

    check_idle("reset");
    check_eq("reset r_data", rsp.r_data, 0);
    check_eq("reset b_resp", rsp.b_resp, 0);
    check_eq("reset r_resp", rsp.r_resp, 0);
    check_eq("reset upd", {upd_a, upd_b}, 0);
    check_eq("reset regs_b", (|first_b) | (|last_b) | (|base_b) | (|flags_b), 0);
    check_all("reset");
    rst_n = 1;
    @(negedge clk);

    // Second instance owns the next 4 KiB window.
    tgt = 1;
    write_req(BASE_B, 32'h0000_1000, 4'hF, 0, 0);
    collect_b(0, r);
    check_eq("inst_b b_resp", r, RESP_OKAY);
    check_eq("inst_b first[0]", first_b[0], 64'h1000);
    tgt = 0;
    check_all("inst_a untouched");
    do_write(BASE_B, 32'h1234, 4'hF, 0, 0, 0);
    do_write(BASE - 4, 32'h1234, 4'hF, 0, 0, 0);
    do_write(BASE + 32'hFFC, 32'h1234, 4'hF, 0, 0, 0);

    // 64-bit first address, then flags with the update pulse.
    do_write(BASE + 32'h00, 32'h1, 4'hF, 0, 0, 0);
    do_write(BASE + 32'h04, 32'h000F_FFFF, 4'hF, 0, 0, 0);
    u0 = upd_seen[0];
    do_write(BASE + 32'h18, 32'h7, 4'hF, 0, 0, 0);
    check_eq("first[0] 64b", first_a[0], 64'h000F_FFFF_0000_0001);
    check_eq("flags[0]", flags_a[0], 3'b111);
    check_eq("upd[0] pulse count", upd_seen[0] - u0, 1);
    do_read(BASE + 32'h18, 0, d);
    check_eq("flags readback", d, 32'h7);

    // W three cycles ahead of AW, B held off for five cycles.
    do_write(BASE + 32'h48, 32'hCAFE_0001, 4'hF, 3, 5, 1);
    check_idle("after held B");
    check_eq("last[2]", last_a[2], 64'hCAFE_0001);

    // Partial strobe merge.
    do_write(BASE + 32'h30, 32'h1122_3344, 4'hF, 0, 0, 0);
    do_write(BASE + 32'h30, 32'hAABB_CCDD, 4'b0010, -2, 0, 0);
    do_read(BASE + 32'h30, 2, d);
    check_eq("strb merge", d, 32'h1122_CC44);

    // Decode errors and reserved word.
    read_req(BASE + 32'h400);
    collect_r(0, d, r);
    check_eq("oob read resp", r, RESP_DECERR);
    check_eq("oob read data", d, 0);
    do_write(32'hA900_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_read(BASE + 32'h1C, 0, d);
    do_write(BASE + 32'h00, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    check_all("after decerr");

    // Read proceeds while a B is still pending.
    write_req(BASE + 32'h68, 32'h5A5A_0F0F, 4'hF, 0, 0);
    model_write(BASE + 32'h68, 32'h5A5A_0F0F, 4'hF, r);
    do_read(BASE + 32'h68, 1, d);
    check_eq("b still pending", rsp.b_valid, 1);
    collect_b(0, r);
    check_eq("pending b_resp", r, RESP_OKAY);

    // Random traffic.
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)), 0);
      else
        do_read(rand_addr(), int'($urandom_range(0, 2)), d);
      if (i % 40 == 39) check_all("random");
    end
    for (int s = 0; s < N; s++)
      check_eq($sformatf("upd count[%0d]", s), upd_seen[s], upd_exp[s]);

    // Reset with both B and R outstanding.
    write_req(BASE + 32'h80, 32'h0BAD_F00D, 4'hF, 0, 0);
    read_req(BASE + 32'h80);
    check_eq("pre-reset b_valid", rsp.b_valid, 1);
    check_eq("pre-reset r_valid", rsp.r_valid, 1);
    #1;
    rst_n = 0;
    #1;
    model_reset();
    check_idle("mid reset");
    check_all("mid reset");
    @(negedge clk);
    rst_n = 1;
    req.b_ready = 1;
    req.r_ready = 1;
    seen_b = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp.b_valid || rsp.r_valid) seen_b++;
    end
    req.b_ready = 0;
    req.r_ready = 0;
    check_eq("spurious resp after reset", seen_b, 0);
    do_write(BASE + 32'h80, 32'h0000_0042, 4'hF, 0, 0, 0);
    do_read(BASE + 32'h80, 0, d);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
